// File: rtl/exe_div_ctrl.sv
// Multi-cycle restoring divider controller for the EXE stage: one quotient bit per cycle.
// Optional feature macro: EXE_DIV_CTRL_EARLY_OUT_EN (skip the iterations when the quotient is trivially 0/all-ones).
module exe_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_req,
  input  logic [3:0]        div_op,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              div_ack,
  output logic              div_ready,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  logic              is_signed_p0;
  logic              is_mod_p0;
  logic              neg_dnd_p0;
  logic              neg_dsr_p0;
  logic              dsr_zero_p0;
  logic              early_p0;
  logic [DATA_W-1:0] src1_p0;
  logic [DATA_W-1:0] dsr_mag_p0;
  logic [DATA_W-1:0] rem_p0;
  logic [DATA_W-1:0] quo_p0;

  logic              sel_signed;
  logic              sel_mod;
  logic              accept;
  logic              neg_dnd;
  logic              neg_dsr;
  logic [DATA_W-1:0] dnd_mag;
  logic [DATA_W-1:0] dsr_mag;
  logic              early_in;
  logic              finish;

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] quo_sh;
  logic              step_ge;
  logic [DATA_W-1:0] rem_nx;

  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v,
                                                input logic                     neg);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return neg ? DATA_W'(n) : DATA_W'(v);
  endfunction

  // Sign fix-up of the unsigned quotient/remainder, plus the divide-by-zero override.
  function automatic logic [DATA_W-1:0] fix_result(input logic [DATA_W-1:0] q,
                                                   input logic [DATA_W-1:0] r,
                                                   input logic [DATA_W-1:0] src1,
                                                   input logic              md,
                                                   input logic              neg_dnd_i,
                                                   input logic              neg_dsr_i,
                                                   input logic              dsr_zero);
    logic [DATA_W-1:0] res;
    if (dsr_zero) begin
      res = md ? src1 : '1;
    end else if (md) begin
      res = neg_dnd_i ? (~r + 1'b1) : r;
    end else begin
      res = (neg_dnd_i ^ neg_dsr_i) ? (~q + 1'b1) : q;
    end
    return res;
  endfunction

  always_comb begin
    sel_signed = 1'b0;
    sel_mod    = 1'b1;
    if (div_op[3]) begin
      sel_signed = 1'b1;
      sel_mod    = 1'b0;
    end else if (div_op[2]) begin
      sel_signed = 1'b1;
      sel_mod    = 1'b1;
    end else if (div_op[1]) begin
      sel_signed = 1'b0;
      sel_mod    = 1'b0;
    end
  end

  assign accept  = div_req && (div_op != 4'b0000);
  assign neg_dnd = sel_signed && div_src1[DATA_W-1];
  assign neg_dsr = sel_signed && div_src2[DATA_W-1];
  assign dnd_mag = abs_mag(div_src1, neg_dnd);
  assign dsr_mag = abs_mag(div_src2, neg_dsr);

`ifdef EXE_DIV_CTRL_EARLY_OUT_EN
  assign early_in = (dsr_mag == '0) || (dnd_mag < dsr_mag);
`else
  assign early_in = 1'b0;
`endif

  assign finish = early_p0 || (cnt == LAST_CNT);

  // One restoring step: shift {rem,quo}, trial-subtract the divisor magnitude.
  assign rem_sh  = {rem_p0, quo_p0[DATA_W-1]};
  assign quo_sh  = {quo_p0[DATA_W-2:0], 1'b0};
  assign step_ge = rem_sh >= {1'b0, dsr_mag_p0};
  assign rem_nx  = step_ge ? (rem_sh[DATA_W-1:0] - dsr_mag_p0) : rem_sh[DATA_W-1:0];

  // ---- control: FSM, iteration count and registered handshake outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      early_p0   <= 1'b0;
      div_ready  <= 1'b1;
      div_done   <= 1'b0;
      div_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RUN;
            cnt       <= '0;
            early_p0  <= early_in;
            div_ready <= 1'b0;
          end
        end
        RUN: begin
          if (finish) begin
            state      <= DONE;
            div_done   <= 1'b1;
            // Early-out path: quotient is 0 and the remainder is the whole dividend.
            div_result <= fix_result(early_p0 ? '0 : quo_p0,
                                     early_p0 ? quo_p0 : rem_p0,
                                     src1_p0, is_mod_p0, neg_dnd_p0, neg_dsr_p0,
                                     dsr_zero_p0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (div_ack) begin
            state     <= IDLE;
            div_done  <= 1'b0;
            div_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          div_done  <= 1'b0;
          div_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---- datapath: operand latch and shift/subtract registers (no reset needed) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      is_signed_p0 <= sel_signed;
      is_mod_p0    <= sel_mod;
      neg_dnd_p0   <= neg_dnd;
      neg_dsr_p0   <= neg_dsr;
      dsr_zero_p0  <= (dsr_mag == '0);
      src1_p0      <= div_src1;
      dsr_mag_p0   <= dsr_mag;
      rem_p0       <= '0;
      quo_p0       <= dnd_mag;
    end else if (state == RUN && !finish) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_sh | {{(DATA_W-1){1'b0}}, step_ge};
    end
  end

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_exe_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req;
  logic [3:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_ack;
  logic        div_ready;
  logic        div_done;
  logic [31:0] div_result;

  int n_checks = 0;
  int n_fail   = 0;

  exe_div_ctrl #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_req   (div_req),
    .div_op    (div_op),
    .div_src1  (div_src1),
    .div_src2  (div_src2),
    .div_ack   (div_ack),
    .div_ready (div_ready),
    .div_done  (div_done),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [3:0] op, output bit sgn, output bit md);
    if (op[3])      begin sgn = 1; md = 0; end
    else if (op[2]) begin sgn = 1; md = 1; end
    else if (op[1]) begin sgn = 0; md = 0; end
    else            begin sgn = 0; md = 1; end
  endfunction

  function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    bit sgn, md;
    logic signed [31:0] sa, sb, sr;
    decode(op, sgn, md);
    if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
    if (!sgn) return md ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    sr = md ? (sa % sb) : (sa / sb);
    return sr;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef EXE_DIV_CTRL_EARLY_OUT_EN
    bit sgn, md;
    logic [31:0] am, bm;
    decode(op, sgn, md);
    am = (sgn && a[31]) ? 32'd0 - a : a;
    bm = (sgn && b[31]) ? 32'd0 - b : b;
    return (bm == 32'd0 || am < bm) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Issue one request, scramble the operand inputs after acceptance, time done, hold, then ack.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] expv;
    int explat;
    int cyc;
    expv   = ref_div(op, a, b);
    explat = ref_lat(op, a, b);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(div_ready), 32'd1);
    div_req  = 1'b1;
    div_op   = op;
    div_src1 = a;
    div_src2 = b;
    @(posedge clk);
    @(negedge clk);
    div_req  = 1'b0;
    div_op   = 4'($urandom);
    div_src1 = $urandom;
    div_src2 = $urandom;
    check({tag, "_ready_busy"}, 32'(div_ready), 32'd0);
    cyc = 0;
    while (!div_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(explat));
    check({tag, "_result"}, div_result, expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_done"}, 32'(div_done), 32'd1);
      check({tag, "_hold_result"}, div_result, expv);
    end
    div_ack = 1'b1;
    @(negedge clk);
    div_ack = 1'b0;
    check({tag, "_ack_done"}, 32'(div_done), 32'd0);
    check({tag, "_ack_ready"}, 32'(div_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb, e;
    int cyc;
    reset    = 1'b1;
    div_req  = 1'b0;
    div_op   = 4'd0;
    div_src1 = 32'd0;
    div_src2 = 32'd0;
    div_ack  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(div_done), 32'd0);
    check("rst_ready", 32'(div_ready), 32'd1);
    check("rst_result", div_result, 32'd0);
    reset = 1'b0;

    // A request with no op bit set must be ignored.
    div_req  = 1'b1;
    div_op   = 4'd0;
    div_src1 = 32'd10;
    div_src2 = 32'd3;
    repeat (3) begin
      @(negedge clk);
      check("op0_ready", 32'(div_ready), 32'd1);
      check("op0_done", 32'(div_done), 32'd0);
    end
    div_req = 1'b0;

    do_op(4'b1000, 32'd100, 32'd7, 0, "divw_100_7");
    do_op(4'b0100, 32'd100, 32'd7, 0, "modw_100_7");
    do_op(4'b1000, 32'hFFFF_FFF9, 32'd2, 0, "divw_m7_2");
    do_op(4'b0100, 32'hFFFF_FFF9, 32'd2, 0, "modw_m7_2");
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd2, 0, "divwu_max_2");
    do_op(4'b0001, 32'hFFFF_FFFF, 32'd2, 0, "modwu_max_2");
    do_op(4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divw_ovf");
    do_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 0, "modw_ovf");
    do_op(4'b0010, 32'd5, 32'd0, 0, "divwu_5_0");
    do_op(4'b0001, 32'd5, 32'd0, 0, "modwu_5_0");
    do_op(4'b1000, 32'hFFFF_FFFB, 32'd0, 0, "divw_m5_0");
    do_op(4'b0100, 32'hFFFF_FFFB, 32'd0, 0, "modw_m5_0");
    do_op(4'b0100, 32'hFFFF_FFFD, 32'd7, 0, "modw_small");
    do_op(4'b1100, 32'd100, 32'd7, 0, "prio_div_over_mod");
    do_op(4'b0011, 32'd100, 32'd7, 0, "prio_divu_over_modu");
    do_op(4'b1000, 32'd1000, 32'd3, 5, "ack_hold");

    // Ack and a new request in the same cycle: the request waits for the next IDLE cycle.
    @(negedge clk);
    div_req  = 1'b1;
    div_op   = 4'b1000;
    div_src1 = 32'd50;
    div_src2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    div_req = 1'b0;
    cyc = 0;
    while (!div_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ackreq_first_result", div_result, 32'd10);
    div_ack  = 1'b1;
    div_req  = 1'b1;
    div_op   = 4'b0100;
    div_src1 = 32'd50;
    div_src2 = 32'd7;
    @(negedge clk);
    div_ack = 1'b0;
    check("ackreq_ready_next", 32'(div_ready), 32'd1);
    check("ackreq_done_low", 32'(div_done), 32'd0);
    @(negedge clk);
    div_req = 1'b0;
    check("ackreq_accepted", 32'(div_ready), 32'd0);
    cyc = 0;
    while (!div_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ackreq_latency", 32'(cyc), 32'(ref_lat(4'b0100, 32'd50, 32'd7)));
    check("ackreq_result", div_result, 32'd1);
    div_ack = 1'b1;
    @(negedge clk);
    div_ack = 1'b0;

    // Reset partway through the iterations.
    div_req  = 1'b1;
    div_op   = 4'b1000;
    div_src1 = 32'd123456;
    div_src2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    div_req = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_done", 32'(div_done), 32'd0);
    check("midrst_ready", 32'(div_ready), 32'd1);
    check("midrst_result", div_result, 32'd0);
    do_op(4'b1000, 32'd9, 32'd3, 0, "after_rst_9_3");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 15));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'd0 - 32'($urandom_range(1, 20));
        3:       rb = ra + 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
      e = ref_div(rop, ra, rb);
      do_op(rop, ra, rb, $urandom_range(0, 2), $sformatf("rnd%0d", i));
      if (e === 32'hx) check("rnd_model_x", e, 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_div_ctrl.md
EXE_DIV_CTRL -- requirements
Module: exe_div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port div_req, input, 1 bit: the EXE stage holds a valid divide instruction.
REQ-004 SHALL have port div_op, input, 4 bits: {div_w, mod_w, div_wu, mod_wu}.
REQ-005 SHALL have ports div_src1 and div_src2, input, 32 bits each: dividend and divisor.
REQ-006 SHALL have port div_ack, input, 1 bit: the consumer takes the result (EXE ready_go and MEM allowin).
REQ-007 SHALL have port div_ready, output, 1 bit: the FSM is IDLE and can accept a request.
REQ-008 SHALL have port div_done, output, 1 bit: div_result is valid; this drives EXE es_ready_go for divide instructions.
REQ-009 SHALL have port div_result, output, 32 bits: the quotient or remainder selected by the latched op.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL accept a request in IDLE when div_req=1 and div_op is non-zero.
- On acceptance: latch the op, operand signs, and 32-bit magnitudes (abs for signed ops; raw for unsigned ops); clear the 6-bit count; go to RUN.
REQ-012 SHALL ignore div_req while div_op=0.
- If div_op has multiple bits set, priority is div_w > mod_w > div_wu > mod_wu.
REQ-013 SHALL run one restoring-division step per cycle in RUN.
- Each step: shift {rem,quo} left by 1; if rem >= divisor magnitude, subtract and set the quotient LSB.
REQ-014 SHALL move from RUN to DONE after exactly 32 steps (count 0..31).
- div_done rises 33 cycles after the acceptance edge.
REQ-015 SHALL fix the result in the cycle DONE is entered.
- Signed quotient is negated when the operand signs differ.
- Signed remainder takes the sign of the dividend.
- div_result is held stable while in DONE.
REQ-016 SHALL, for divisor=0 on any op, return quotient 0xFFFFFFFF and remainder div_src1, regardless of sign.
REQ-017 SHALL, for signed 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-018 SHALL hold DONE with div_done=1 until div_ack=1, then return to IDLE on the next edge.
REQ-019 SHALL NOT accept a new request while in RUN or DONE.
- div_ready=0 in those states.
- A request arriving in the same cycle as the ack is accepted no earlier than the following IDLE cycle.
REQ-020 SHALL ignore div_ack outside DONE.
REQ-021 SHALL ignore changes on div_src1, div_src2 and div_op after acceptance.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, go to IDLE from any state, including mid-RUN and DONE, and discard any partial result.
REQ-023 SHALL hold these values while in reset: div_done=0, div_ready=1, div_result=0, count=0.

Configuration
REQ-024 SHALL gate early termination with the macro EXE_DIV_CTRL_EARLY_OUT_EN.
REQ-025 SHALL, with the macro defined, go from IDLE directly to DONE when either condition holds, so div_done rises 1 cycle after acceptance:
- divisor magnitude is 0 (results per REQ-016);
- dividend magnitude < divisor magnitude (quotient 0, remainder = div_src1).
REQ-026 SHALL, with the macro undefined, take all 33 cycles on every path, with identical result values.

Verification
REQ-027 SHALL cover signed divide and modulo:
- div_w 100/7 -> div_result 0x0000000E at acceptance+33; mod_w 100/7 -> 0x00000002.
- div_w 0xFFFFFFF9/0x00000002 -> 0xFFFFFFFD; mod_w -> 0xFFFFFFFF.
REQ-028 SHALL cover unsigned divide:
- div_wu 0xFFFFFFFF/2 -> 0x7FFFFFFF; mod_wu -> 0x00000001.
REQ-029 SHALL cover the boundary cases:
- div_w 0x80000000/0xFFFFFFFF -> 0x80000000; mod_w -> 0.
- div_wu 5/0 -> 0xFFFFFFFF; mod_wu 5/0 -> 5 (done at +1 with EXE_DIV_CTRL_EARLY_OUT_EN, +33 without).
REQ-030 SHALL cover ack hold:
- Hold div_ack=0 for 5 cycles after done: div_done and div_result stay stable.
- div_ack=1 with div_req=1 in the same cycle: div_ready=1 on the next cycle, acceptance one cycle later.
REQ-031 SHALL cover reset mid-operation:
- Assert reset at RUN count 10: next cycle shows IDLE, div_done=0, div_ready=1.
- A following request div_w 9/3 -> 0x00000003.
